lin_calc_period_gen: RTL and testbench
======================================

# lin_calc_period_gen

Programmable periodic tick generator that consumes the result of the iterative linear calculator (y = m*x + b) and turns it into a clock-cycle period. It sits directly downstream of the calculator, with its y/valid pair wired straight in. It emits one-cycle tick pulses every y clock cycles, for example SPI bit or word pacing. Period changes are shadowed and applied only at a period boundary, so ticks never glitch.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  run request; level-sensitive
- y  input  32  period in clk cycles, from calculator output
- y_valid  input  1  calculator valid; level, may stay high many cycles
- tick  output  1  registered one-cycle pulse at each period boundary
- period  output  32  period currently being counted
- busy  output  1  high while in S_RUN
- tick_cnt  output  32  ticks since start; present only with LIN_CALC_PERIOD_GEN_TICK_CNT_EN

## Operation
- Shadow register:
  - shadow <= y on every edge with y_valid=1.
  - shadow_vld is set on the first y_valid and cleared only by reset.
- FSM states:
  - S_IDLE=0: cnt=0, tick=0.
  - S_RUN=1.
- S_IDLE -> S_RUN when en=1 && shadow_vld && shadow!=0. On that edge: period<=shadow, cnt<=shadow-1.
- S_RUN, en=0: go to S_IDLE at the next edge; tick<=0, cnt<=0, period holds its last value.
- S_RUN, cnt!=0: cnt<=cnt-1, tick<=0.
- S_RUN, cnt==0:
  - tick<=1.
  - If shadow!=0: period<=shadow, cnt<=shadow-1.
  - If shadow==0: go to S_IDLE.
- Reload always uses the registered shadow. A y_valid on the reload edge updates shadow, and the new value takes effect at the following boundary.
- Period 1: cnt stays 0, so tick is high every cycle.
- Period 0: never entered; the block stays in (or returns to) S_IDLE.
- No overflow protection. Any 32-bit y is legal; 0xFFFFFFFF gives the maximum period.

## Timing
- Reset values: tick=0, period=0, busy=0, tick_cnt=0, shadow=0, shadow_vld=0, cnt=0, FSM=S_IDLE.
- Reset mid-run:
  - Asserting rst_n low drops tick and busy immediately (asynchronously).
  - No tick follows deassertion until a fresh start.
- Start latency: with en rising at edge E, the first tick is high in the cycle after edge E+P (P = loaded period).
- Steady state: tick rising edges exactly P cycles apart; duty is 1/P (continuous high for P=1).
- busy is high in the cycle after the S_IDLE->S_RUN edge and low in the cycle after the S_RUN->S_IDLE edge.
- y changing while y_valid=0 has no effect.

## Configuration
- LIN_CALC_PERIOD_GEN_TICK_CNT_EN defined:
  - Adds the tick_cnt output.
  - tick_cnt increments on each edge that sets tick<=1 and wraps 0xFFFFFFFF->0.
  - Cleared on reset and on each S_IDLE->S_RUN transition.
- Macro undefined: the tick_cnt port and its counter logic are absent; all other behaviour is identical.

## Structure
- Shared package: S_IDLE/S_RUN state localparams and the 32-bit width constant, both reused by the calculator and the SPI master.
- One natural sub-module: period_down_cnt, a loadable 32-bit down-counter.
  - Inputs: load, load value, dec.
  - Output: zero flag.
- The FSM, shadow register and tick register stay in the top module.

## Test plan
- Reset with y=5, y_valid=1, then en=1 at edge E -> ticks in the cycles after edges E+5, E+10, E+15; period=5, busy=1.
- y=1, run -> tick continuously high; tick_cnt (macro on) increments by 1 each cycle.
- Running at P=4, y_valid pulses y=7 mid-period -> the current period completes at 4 cycles, the next interval is 7; y=7 pulsed exactly on the reload edge -> one more 4-cycle interval, then 7.
- y=0 with y_valid while running at P=3 -> the pending tick fires, then the FSM goes to S_IDLE and busy=0; en=1 with shadow=0 stays idle.
- en=1 before any y_valid -> no tick and busy=0; first y_valid with y=2 -> start on the next edge.
- rst_n low mid-period at P=6 -> tick/busy/period clear immediately; after release with en=1 and no new y_valid -> no ticks.

Source files
------------

// File: rtl/lin_calc_period_gen_pkg.sv
// rtl/lin_calc_period_gen_pkg.sv - shared width and run/idle state encoding
package lin_calc_period_gen_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/lin_calc_period_gen_period_down_cnt.sv
// rtl/lin_calc_period_gen_period_down_cnt.sv - loadable down-counter that holds at zero
module lin_calc_period_gen_period_down_cnt
  import lin_calc_period_gen_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [DATA_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lin_calc_period_gen.sv
// rtl/lin_calc_period_gen.sv - shadowed-period tick generator fed by the linear calculator
// Optional tick counter output: LIN_CALC_PERIOD_GEN_TICK_CNT_EN
module lin_calc_period_gen
  import lin_calc_period_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] y,
  input  logic              y_valid,
  output logic              tick,
  output logic [DATA_W-1:0] period,
  output logic              busy
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
  ,
  output logic [DATA_W-1:0] tick_cnt
`endif
);

  run_state_e        r_state;
  run_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_shadow;
  logic              r_shadow_vld;
  logic              r_tick;
  logic              w_tick_nxt;
  logic [DATA_W-1:0] r_period;
  logic [DATA_W-1:0] w_period_nxt;
  logic              w_load;
  logic [DATA_W-1:0] w_load_val;
  logic              w_dec;
  logic              w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else if (y_valid) begin
      r_shadow     <= y;
      r_shadow_vld <= 1'b1;
    end
  end

  lin_calc_period_gen_period_down_cnt u_down_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tick   <= 1'b0;
      r_period <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_period <= w_period_nxt;
    end
  end

  // Reloads always come from the registered shadow, never straight from y.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = 1'b0;
    w_period_nxt = r_period;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_dec        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && r_shadow_vld && (r_shadow != '0)) begin
          w_state_nxt  = S_RUN;
          w_load       = 1'b1;
          w_load_val   = r_shadow - 32'd1;
          w_period_nxt = r_shadow;
        end
      end
      S_RUN: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_load      = 1'b1;
        end else if (!w_zero) begin
          w_dec = 1'b1;
        end else begin
          w_tick_nxt = 1'b1;
          if (r_shadow != '0) begin
            w_load       = 1'b1;
            w_load_val   = r_shadow - 32'd1;
            w_period_nxt = r_shadow;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
  logic [DATA_W-1:0] r_tick_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_RUN)) begin
      r_tick_cnt <= '0;
    end else if (w_tick_nxt) begin
      r_tick_cnt <= r_tick_cnt + 32'd1;
    end
  end

  assign tick_cnt = r_tick_cnt;
`endif

  assign tick   = r_tick;
  assign period = r_period;
  assign busy   = (r_state == S_RUN);

endmodule

// File: tb/tb_lin_calc_period_gen.sv
// tb/tb_lin_calc_period_gen.sv - directed bench with a deadline-based reference model
module tb_lin_calc_period_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] y = 32'd0;
  logic        y_valid = 1'b0;
  logic        tick;
  logic [31:0] period;
  logic        busy;
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
  logic [31:0] tick_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lin_calc_period_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .y        (y),
    .y_valid  (y_valid),
    .tick     (tick),
    .period   (period),
    .busy     (busy)
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  // Model: remembers the absolute edge at which the next tick is due.
  longint      m_edge;
  longint      m_due;
  logic        m_run;
  logic        m_tick;
  logic [31:0] m_period;
  logic [31:0] m_shadow;
  logic        m_vld;
  logic [31:0] m_tc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge <= 0; m_due <= 0; m_run <= 1'b0; m_tick <= 1'b0;
      m_period <= 32'd0; m_shadow <= 32'd0; m_vld <= 1'b0; m_tc <= 32'd0;
    end else begin
      m_edge <= m_edge + 1;
      if (y_valid) begin
        m_shadow <= y;
        m_vld    <= 1'b1;
      end
      m_tick <= 1'b0;
      if (!m_run) begin
        if (en && m_vld && m_shadow != 32'd0) begin
          m_run    <= 1'b1;
          m_period <= m_shadow;
          m_due    <= m_edge + longint'(m_shadow);
          m_tc     <= 32'd0;
        end
      end else if (!en) begin
        m_run <= 1'b0;
      end else if (m_edge == m_due) begin
        m_tick <= 1'b1;
        m_tc   <= m_tc + 32'd1;
        if (m_shadow != 32'd0) begin
          m_period <= m_shadow;
          m_due    <= m_edge + longint'(m_shadow);
        end else begin
          m_run <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
    chk("model_busy", {31'd0, busy}, {31'd0, m_run});
    chk("model_period", period, m_period);
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
    chk("model_tick_cnt", tick_cnt, m_tc);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until tick is seen high; -1 if the bound expires.
  task automatic wait_tick(input int maxc, output int n);
    int k;
    k = 0;
    n = -1;
    while (k < maxc) begin
      @(negedge clk);
      k++;
      if (tick) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic load_y(input logic [31:0] v);
    y = v;
    y_valid = 1'b1;
    cyc(1);
    y_valid = 1'b0;
  endtask

  int n;
  int ticks;
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
  logic [31:0] tc0;
`endif

  initial begin
    rst_n = 1'b0; y = 32'd5; y_valid = 1'b1; en = 1'b0;
    cyc(2);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_period", period, 32'd0);
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
    chk("rst_tick_cnt", tick_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    cyc(1);
    y_valid = 1'b0;
    en = 1'b1;
    // first tick seen at the 6th negedge: the cycle after edge E+5
    wait_tick(20, n); chk("p5_first", n, 32'd6);
    wait_tick(20, n); chk("p5_second", n, 32'd5);
    wait_tick(20, n); chk("p5_third", n, 32'd5);
    chk("p5_period", period, 32'd5);
    chk("p5_busy", {31'd0, busy}, 32'd1);

    // switch to P=1: the running 5-cycle interval completes first
    load_y(32'd1);
    wait_tick(20, n); chk("p5_before_p1", n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      wait_tick(3, n); chk("p1_cont", n, 32'd1);
    end
    chk("p1_period", period, 32'd1);
`ifdef LIN_CALC_PERIOD_GEN_TICK_CNT_EN
    tc0 = tick_cnt;
    cyc(1);
    chk("p1_tick_cnt_inc", tick_cnt, tc0 + 32'd1);
`endif
    en = 1'b0;
    cyc(3);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_period_hold", period, 32'd1);

    // P=4 with y=7 pulsed mid-period
    load_y(32'd4);
    en = 1'b1;
    wait_tick(20, n); chk("p4_first", n, 32'd5);
    cyc(1);
    y = 32'd7; y_valid = 1'b1;
    cyc(1);
    y_valid = 1'b0;
    wait_tick(20, n); chk("mid_rest_of_4", n, 32'd2);
    wait_tick(20, n); chk("mid_next_7", n, 32'd7);
    en = 1'b0;
    cyc(3);

    // P=4 with y=7 pulsed exactly on the reload edge
    load_y(32'd4);
    en = 1'b1;
    wait_tick(20, n); chk("re_first", n, 32'd5);
    wait_tick(20, n); chk("re_second", n, 32'd4);
    cyc(3);
    y = 32'd7; y_valid = 1'b1;
    cyc(1);
    chk("re_edge_tick", {31'd0, tick}, 32'd1);
    y_valid = 1'b0;
    wait_tick(20, n); chk("re_old_4", n, 32'd4);
    wait_tick(20, n); chk("re_new_7", n, 32'd7);
    en = 1'b0;
    cyc(3);

    // y=0 while running at P=3
    load_y(32'd3);
    en = 1'b1;
    wait_tick(20, n); chk("p3_first", n, 32'd4);
    load_y(32'd0);
    wait_tick(20, n); chk("p0_pending_tick", n, 32'd2);
    chk("p0_busy_drop", {31'd0, busy}, 32'd0);
    cyc(6);
    chk("p0_stay_idle", {31'd0, busy}, 32'd0);

    // en before any y_valid
    en = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    en = 1'b1;
    y = 32'd2;
    cyc(5);
    chk("novld_busy", {31'd0, busy}, 32'd0);
    y_valid = 1'b1;
    cyc(1);
    chk("vld_capture_edge", {31'd0, busy}, 32'd0);
    y_valid = 1'b0;
    cyc(1);
    chk("vld_start_next", {31'd0, busy}, 32'd1);
    chk("vld_period", period, 32'd2);
    en = 1'b0;
    cyc(3);

    // asynchronous reset while tick is high at P=6
    load_y(32'd6);
    en = 1'b1;
    wait_tick(20, n); chk("p6_first", n, 32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("async_tick", {31'd0, tick}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_period", period, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("post_rst_ticks", ticks, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
